// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: run-monitor
// states, MMIO window layout, status bit positions and status write codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  // Byte offsets of the three MMIO words relative to MMIO_BASE.
  localparam logic [31:0] OFF_STATUS = 32'd0;
  localparam logic [31:0] OFF_CYCLES = 32'd4;
  localparam logic [31:0] OFF_STORES = 32'd8;
  localparam logic [31:0] MMIO_BYTES = 32'd12;

  // Bit positions inside the status word.
  localparam int BIT_DONE = 0;
  localparam int BIT_PASS = 1;
  localparam int BIT_FAIL = 2;

  // Values a program stores to the status word to end the run.
  localparam logic [31:0] CODE_PASS = 32'd1;
  localparam logic [31:0] CODE_FAIL = 32'd2;

  // Status word as seen by a load of MMIO_BASE+0.
  function automatic logic [31:0] status_word(input state_e s);
    logic [31:0] w;
    w           = '0;
    w[BIT_DONE] = (s != ST_RUN);
    w[BIT_PASS] = (s == ST_PASS);
    w[BIT_FAIL] = (s == ST_FAIL);
    return w;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with asynchronous read and synchronous write.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Store one word per enabled clock edge.
  // NOTE: the array has no reset; clearing DEPTH words would need a reset
  // fan-out to every cell and forbid mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read path is combinational, so a same-cycle store is seen only next cycle.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the single-cycle MIPS data port: word RAM, a three-word
// MMIO status/counter window and a run monitor that classifies the program
// outcome as PASS or FAIL.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH         = 64,
  parameter logic [31:0] MMIO_BASE     = 32'hFFFF_0000,
  parameter logic [31:0] SENTINEL_ADDR = 32'd84,
  parameter logic [31:0] SENTINEL_DATA = 32'd7,
  parameter logic [31:0] TIMEOUT       = 32'd10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] err_addr
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  state_e      state_q,     state_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;
  logic [31:0] err_addr_q,  err_addr_d;

  logic          misaligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic          unmapped;
  logic [31:0]   mmio_off;
  logic [AW-1:0] word_idx;
  logic          ram_we;
  logic [31:0]   ram_rdata;

  // Address decode. The MMIO test is written as base <= addr and an offset
  // bound so a window near the top of the address space cannot wrap.
  assign misaligned = |dataadr[1:0];
  assign ram_hit    = (dataadr < RAM_BYTES);
  assign mmio_off   = dataadr - MMIO_BASE;
  assign mmio_hit   = (dataadr >= MMIO_BASE) && (mmio_off < MMIO_BYTES) && !misaligned;
  assign unmapped   = !ram_hit && !mmio_hit;
  assign word_idx   = dataadr[AW+1:2];

  // RAM keeps accepting stores after the run ends; a store coincident with
  // reset is dropped.
  assign ram_we = memwrite && ram_hit && !misaligned && !rst;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_idx),
    .wdata (writedata),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  // Load mux: RAM word, MMIO register, or zero for anything else.
  always_comb begin
    readdata = '0;
    if (!misaligned) begin
      if (ram_hit) begin
        readdata = ram_rdata;
      end else if (mmio_hit) begin
        case (mmio_off)
          OFF_STATUS: readdata = status_word(state_q);
          OFF_CYCLES: readdata = cycle_cnt_q;
          OFF_STORES: readdata = store_cnt_q;
          default:    readdata = '0;
        endcase
      end
    end
  end

  // Run-monitor next state, counters and error address; PASS/FAIL absorb.
  // NOTE: every variable gets its hold value first so no path through the
  // branches leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    store_cnt_d = store_cnt_q;
    err_addr_d  = err_addr_q;
    if (state_q == ST_RUN) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      store_cnt_d = store_cnt_q + 32'(memwrite);
      if (memwrite && misaligned) begin
        state_d    = ST_FAIL;
        err_addr_d = dataadr;
      end else if (memwrite && (dataadr == SENTINEL_ADDR)) begin
        if (writedata == SENTINEL_DATA) begin
          state_d = ST_PASS;
        end else begin
          state_d    = ST_FAIL;
          err_addr_d = dataadr;
        end
      end else if (memwrite && mmio_hit && (mmio_off == OFF_STATUS) &&
                   (writedata == CODE_PASS)) begin
        state_d = ST_PASS;
      end else if (memwrite && mmio_hit && (mmio_off == OFF_STATUS) &&
                   (writedata == CODE_FAIL)) begin
        state_d    = ST_FAIL;
        err_addr_d = dataadr;
      end else if (memwrite && unmapped) begin
        state_d    = ST_FAIL;
        err_addr_d = dataadr;
      end else if (cycle_cnt_q == TIMEOUT - 32'd1) begin
        state_d = ST_FAIL;
      end
    end
  end

  // State register with synchronous reset.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cycle_cnt_q <= '0;
      store_cnt_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      store_cnt_q <= store_cnt_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign done     = (state_q != ST_RUN);
  assign pass     = (state_q == ST_PASS);
  assign fail     = (state_q == ST_FAIL);
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a behavioural
// model of the run monitor and memory.
module tb_dmem_responder;

  localparam int          DEPTH         = 64;
  localparam int          AW            = 6;
  localparam logic [31:0] MMIO_BASE     = 32'hFFFF_0000;
  localparam logic [31:0] SENTINEL_ADDR = 32'd84;
  localparam logic [31:0] SENTINEL_DATA = 32'd7;
  localparam logic [31:0] TIMEOUT       = 32'd20;

  localparam int M_RUN  = 0;
  localparam int M_PASS = 1;
  localparam int M_FAIL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        done, pass, fail;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH         (DEPTH),
    .MMIO_BASE     (MMIO_BASE),
    .SENTINEL_ADDR (SENTINEL_ADDR),
    .SENTINEL_DATA (SENTINEL_DATA),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .err_addr  (err_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          st;
    logic [31:0] cyc;
    logic [31:0] stores;
    logic [31:0] err;
  } mstate_t;

  mstate_t     m;
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_valid = 1'b0;

  function automatic bit is_ram(input logic [31:0] a);
    return (a < 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a == MMIO_BASE) || (a == MMIO_BASE + 32'd4) || (a == MMIO_BASE + 32'd8);
  endfunction

  // One clock of the run monitor, straight from the outcome rules.
  function automatic mstate_t model_next(input mstate_t cur, input logic r, input logic we,
                                         input logic [31:0] a, input logic [31:0] d);
    mstate_t n;
    bit      mis;
    n   = cur;
    mis = (a[1:0] != 2'b00);
    if (r) begin
      n.st = M_RUN; n.cyc = 0; n.stores = 0; n.err = 0;
      return n;
    end
    if (cur.st != M_RUN) return n;
    if (we && mis) begin
      n.st = M_FAIL; n.err = a;
    end else if (we && a == SENTINEL_ADDR) begin
      if (d == SENTINEL_DATA) n.st = M_PASS;
      else begin n.st = M_FAIL; n.err = a; end
    end else if (we && a == MMIO_BASE && d == 32'd1) begin
      n.st = M_PASS;
    end else if (we && a == MMIO_BASE && d == 32'd2) begin
      n.st = M_FAIL; n.err = a;
    end else if (we && !(a < 32'(4 * DEPTH)) && !is_mmio(a)) begin
      n.st = M_FAIL; n.err = a;
    end else if (cur.cyc == TIMEOUT - 1) begin
      n.st = M_FAIL;
    end
    n.cyc    = cur.cyc + 1;
    n.stores = cur.stores + (we ? 32'd1 : 32'd0);
    return n;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[1:0] != 2'b00)            return 32'h0;
    if (a < 32'(4 * DEPTH))         return m_mem[a[AW+1:2]];
    if (a == MMIO_BASE)             return {29'b0, m.st == M_FAIL, m.st == M_PASS, m.st != M_RUN};
    if (a == MMIO_BASE + 32'd4)     return m.cyc;
    if (a == MMIO_BASE + 32'd8)     return m.stores;
    return 32'h0;
  endfunction

  function automatic bit read_known(input logic [31:0] a);
    if (is_ram(a)) return m_known[a[AW+1:2]];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, rst, memwrite, dataadr, writedata);
    if (rst) m_valid <= 1'b1;
    if (!rst && memwrite && is_ram(dataadr)) begin
      m_mem[dataadr[AW+1:2]]   <= writedata;
      m_known[dataadr[AW+1:2]] <= 1'b1;
    end
  end

  // Compare process: all outputs every cycle once the model is initialised.
  always @(negedge clk) begin
    if (m_valid) begin
      check("done",     32'(done),  32'(m.st != M_RUN));
      check("pass",     32'(pass),  32'(m.st == M_PASS));
      check("fail",     32'(fail),  32'(m.st == M_FAIL));
      check("err_addr", err_addr,   m.err);
      if (read_known(dataadr)) check("readdata", readdata, model_read(dataadr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; memwrite = we; dataadr = a; writedata = d;
  endtask

  task automatic probe(input logic [31:0] a);
    drive(1'b0, 1'b0, a, 32'h0);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int first_fail;
    logic [31:0] a, d;

    do_reset();
    do_reset();
    probe(MMIO_BASE + 32'd4);
    check("lit_reset_cycles", readdata, 32'd0);
    check("lit_reset_done",   32'(done), 32'd0);
    check("lit_reset_err",    err_addr, 32'd0);

    // Sentinel success.
    drive(1'b0, 1'b1, 32'h50, 32'd7);
    drive(1'b0, 1'b1, 32'h54, 32'd7);
    probe(MMIO_BASE + 32'd8);
    check("lit_a_stores", readdata, 32'd2);
    check("lit_a_pass",   32'(pass), 32'd1);
    check("lit_a_done",   32'(done), 32'd1);
    probe(32'h50);
    check("lit_a_ram50",  readdata, 32'd7);

    // Sentinel with wrong data, memory keeps working afterwards.
    do_reset();
    drive(1'b0, 1'b1, 32'h54, 32'd5);
    probe(MMIO_BASE + 32'd8);
    check("lit_b_fail",   32'(fail), 32'd1);
    check("lit_b_err",    err_addr, 32'd84);
    drive(1'b0, 1'b1, 32'h10, 32'hAB);
    probe(32'h10);
    check("lit_b_ram10",  readdata, 32'hAB);
    probe(MMIO_BASE + 32'd8);
    check("lit_b_stores", readdata, 32'd1);

    // Misaligned store with sentinel-like data.
    do_reset();
    drive(1'b0, 1'b1, 32'h10, 32'h55);
    drive(1'b0, 1'b1, 32'h13, 32'd7);
    probe(32'h10);
    check("lit_c_ram10",  readdata, 32'h55);
    check("lit_c_fail",   32'(fail), 32'd1);
    check("lit_c_err",    err_addr, 32'h13);

    // Status write of pass code after idle cycles.
    do_reset();
    repeat (4) drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, MMIO_BASE, 32'd1);
    probe(MMIO_BASE + 32'd4);
    check("lit_d_cycles", readdata, 32'd5);
    check("lit_d_pass",   32'(pass), 32'd1);
    probe(MMIO_BASE);
    check("lit_d_status", readdata, 32'd3);

    // Timeout with no stores.
    do_reset();
    first_fail = -1;
    for (int n = 1; n <= 40; n++) begin
      probe(32'h400);
      if (n == 1) check("lit_e_unmapped", readdata, 32'd0);
      if (fail && first_fail < 0) first_fail = n - 1;
    end
    check("lit_e_timeout_cycle", 32'(first_fail), 32'd20);
    check("lit_e_err", err_addr, 32'd0);

    // Reset while in FAIL with a store pending: store must be dropped.
    drive(1'b1, 1'b1, 32'h54, 32'd7);
    probe(MMIO_BASE + 32'd4);
    check("lit_f_cycles", readdata, 32'd0);
    check("lit_f_fail",   32'(fail), 32'd0);
    check("lit_f_err",    err_addr, 32'd0);
    probe(32'h54);
    check("lit_f_ram54",  readdata, 32'd5);
    probe(MMIO_BASE + 32'd8);
    check("lit_f_stores", readdata, 32'd0);

    // Randomized traffic, compared every cycle against the model.
    for (int round = 0; round < 8; round++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
          4:          a = SENTINEL_ADDR;
          5:          a = MMIO_BASE + 32'($urandom_range(0, 2)) * 32'd4;
          6:          a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
          7:          a = MMIO_BASE + 32'd12;
          8:          a = 32'h400 + 32'($urandom_range(0, 255)) * 32'd4;
          default:    a = $urandom();
        endcase
        if (a == SENTINEL_ADDR)  d = ($urandom_range(0, 1) == 0) ? SENTINEL_DATA : $urandom();
        else if (a == MMIO_BASE) d = 32'($urandom_range(0, 3));
        else                     d = $urandom();
        drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), a, d);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
